// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the adder-sharing controller: operand width and FSM states.
package adder_share_ctrl_pkg;

  localparam int ADDER_BIT_WIDTH = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_share_ctrl_rr_grant.sv
// Round-robin grant: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
// Combinational; grant is one-hot, or all zero when nothing is valid.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  logic [ID_W:0] idx;
  logic          found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found                    = 1'b1;
        winner                   = idx[ID_W-1:0];
        grant[idx[ID_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/structural_adder.sv
// Unsigned ripple-carry adder built from per-bit full-adder equations.
// Purely combinational; the MSB of sum is the carry-out.
module structural_adder #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    sum[WIDTH] = carry;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one structural_adder among NUM_REQ requesters with round-robin arbitration.
// One op in flight: accept -> ADD (1 cycle) -> RESP held until rsp_ready.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ADDER_BIT_WIDTH,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_ptr;
  logic               fire;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH:0]     sum_q;
  logic [WIDTH:0]     add_sum;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (winner)
  );

  structural_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum)
  );

  // Grant is only offered in IDLE and never while reset is asserted.
  assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;
  assign fire      = |(req_valid & req_ready);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (fire) state_d = ADD;
      end
      ADD: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The pointer moves on accept only, so a stalled response never skews fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      sum_q  <= '0;
    end else begin
      if (fire) begin
        a_q  <= req_a[winner*WIDTH +: WIDTH];
        b_q  <= req_b[winner*WIDTH +: WIDTH];
        id_q <= winner;
        if (winner == ID_W'(NUM_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= winner + ID_W'(1);
        end
      end
      if (state == ADD) begin
        sum_q <= add_sum;
      end
    end
  end

endmodule
